// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, refresh FSM states, default timing.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sdram_pkg;

   // {CS_N, RAS_N, CAS_N, WE_N}
   localparam logic [3:0] CMD_NOP       = 4'b0111;
   localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
   localparam logic [3:0] CMD_AREF      = 4'b0001;

   // A10 high selects all banks for PRECHARGE
   localparam logic [12:0] ADDR_PRE_ALL = 13'h0400;

   // Default timing at 50 MHz
   localparam int DEF_REF_PERIOD = 375;
   localparam int DEF_TRP_CYC    = 2;
   localparam int DEF_TRFC_CYC   = 4;
   localparam int DEF_TIMER_W    = 9;

   // Command-spacing counter width, independent of the refresh timer width
   localparam int WAIT_W = 3;

   typedef enum logic [2:0] {
      AREF_IDLE,
      AREF_REQ,
      AREF_PRE,
      AREF_WAIT_RP,
      AREF_AREF,
      AREF_WAIT_RFC,
      AREF_DONE
   } aref_state_t;

endpackage

// File: rtl/sdram_ref_timer.sv
// Free-running period counter: counts 0..PERIOD-1 while en=1, held at 0 while en=0.
// Latency: tick is combinational from the count register, high during the terminal-count cycle.
// Backpressure: none; never stalls.
module sdram_ref_timer #(
   parameter int PERIOD = 375,
   parameter int W      = 9
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   logic [W-1:0] count;

   // Period counter, cleared whenever the enable drops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (!en) begin
         count <= '0;
      end else if (count == W'(PERIOD - 1)) begin
         count <= '0;
      end else begin
         count <= count + W'(1);
      end
   end

   assign tick = en && (count == W'(PERIOD - 1));

endmodule

// File: rtl/sdram_aref.sv
// SDRAM auto-refresh engine: periodic PRECHARGE-ALL + AUTO REFRESH bursts; optional REF_OVERRUN_EN sticky overrun flag.
// Latency: grant sampled at t -> PRECHARGE t+1, AUTO_REFRESH t+4, flag_aref_end t+9 (defaults).
// Backpressure: holds aref_req until aref_en; at most one request queued, extra ticks are dropped.
module sdram_aref
   import sdram_pkg::*;
#(
   parameter int REF_PERIOD = DEF_REF_PERIOD,
   parameter int TRP_CYC    = DEF_TRP_CYC,
   parameter int TRFC_CYC   = DEF_TRFC_CYC,
   parameter int TIMER_W    = DEF_TIMER_W
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flag_init_end,
   input  logic        aref_en,
   output logic        aref_req,
   output logic        flag_aref_end,
   output logic [3:0]  aref_cmd,
   output logic [12:0] aref_addr,
   output logic        ref_overrun
);

   aref_state_t       state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              tick;
   logic              pending;
   logic              pend_clr;
   logic              pend_any;

   sdram_ref_timer #(
      .PERIOD (REF_PERIOD),
      .W      (TIMER_W)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (flag_init_end),
      .tick  (tick)
   );

   // Grant accepted: the queued request is consumed as the FSM leaves REQ
   assign pend_clr = (state == AREF_REQ) && flag_init_end && aref_en;
   // Include a same-cycle tick so DONE/IDLE can go straight to REQ
   assign pend_any = flag_init_end && (pending || tick);

   // Single-entry request queue; tick wins over a simultaneous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
      end else if (!flag_init_end) begin
         pending <= 1'b0;
      end else if (tick) begin
         pending <= 1'b1;
      end else if (pend_clr) begin
         pending <= 1'b0;
      end
   end

`ifdef REF_OVERRUN_EN
   logic overrun_evt;
   assign overrun_evt = tick && pending && !pend_clr;

   // Sticky record of any refresh tick lost while a request was still waiting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_overrun <= 1'b0;
      end else if (overrun_evt) begin
         ref_overrun <= 1'b1;
      end
   end
`else
   assign ref_overrun = 1'b0;
`endif

   // Refresh sequencer with registered command/address/handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= AREF_IDLE;
         wait_cnt      <= '0;
         aref_req      <= 1'b0;
         flag_aref_end <= 1'b0;
         aref_cmd      <= CMD_NOP;
         aref_addr     <= '0;
      end else begin
         aref_req      <= 1'b0;
         flag_aref_end <= 1'b0;
         aref_cmd      <= CMD_NOP;
         aref_addr     <= '0;
         case (state)
            AREF_IDLE: begin
               if (pend_any) begin
                  state    <= AREF_REQ;
                  aref_req <= 1'b1;
               end
            end
            AREF_REQ: begin
               if (!flag_init_end) begin
                  state <= AREF_IDLE;
               end else if (aref_en) begin
                  state     <= AREF_PRE;
                  aref_cmd  <= CMD_PRECHARGE;
                  aref_addr <= ADDR_PRE_ALL;
               end else begin
                  aref_req <= 1'b1;
               end
            end
            AREF_PRE: begin
               state    <= AREF_WAIT_RP;
               wait_cnt <= WAIT_W'(TRP_CYC - 1);
            end
            AREF_WAIT_RP: begin
               if (wait_cnt == '0) begin
                  state    <= AREF_AREF;
                  aref_cmd <= CMD_AREF;
               end else begin
                  wait_cnt <= wait_cnt - WAIT_W'(1);
               end
            end
            AREF_AREF: begin
               state    <= AREF_WAIT_RFC;
               wait_cnt <= WAIT_W'(TRFC_CYC - 1);
            end
            AREF_WAIT_RFC: begin
               if (wait_cnt == '0) begin
                  state         <= AREF_DONE;
                  flag_aref_end <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - WAIT_W'(1);
               end
            end
            AREF_DONE: begin
               if (pend_any) begin
                  state    <= AREF_REQ;
                  aref_req <= 1'b1;
               end else begin
                  state <= AREF_IDLE;
               end
            end
            default: state <= AREF_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_aref.sv
// Directed bench for sdram_aref: latency, hold-off, overrun, back-to-back, init drop, async reset.
// Latency: n/a.
// Backpressure: aref_en driven directly by the bench.
module tb_sdram_aref;

   localparam logic [3:0]  T_NOP = 4'b0111;
   localparam logic [3:0]  T_PRE = 4'b0010;
   localparam logic [3:0]  T_REF = 4'b0001;
   localparam logic [12:0] T_A10 = 13'h0400;

`ifdef REF_OVERRUN_EN
   localparam logic OVR_EXP = 1'b1;
`else
   localparam logic OVR_EXP = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        flag_init_end;
   logic        aref_en;
   logic        aref_req;
   logic        flag_aref_end;
   logic [3:0]  aref_cmd;
   logic [12:0] aref_addr;
   logic        ref_overrun;

   int n_cmp;
   int n_bad;

   sdram_aref dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flag_init_end (flag_init_end),
      .aref_en       (aref_en),
      .aref_req      (aref_req),
      .flag_aref_end (flag_aref_end),
      .aref_cmd      (aref_cmd),
      .aref_addr     (aref_addr),
      .ref_overrun   (ref_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   task automatic wait_req(input int max, output int n);
      n = 0;
      while (aref_req !== 1'b1 && n < max) begin
         step();
         n++;
      end
   endtask

   task automatic wait_cmd(input logic [3:0] c, input int max, output int n);
      n = 0;
      while (aref_cmd !== c && n < max) begin
         step();
         n++;
      end
   endtask

   task automatic wait_end(input int max, output int n);
      n = 0;
      while (flag_aref_end !== 1'b1 && n < max) begin
         step();
         n++;
      end
   endtask

   initial begin
      int n;
      int bad;
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      flag_init_end = 1'b0;
      aref_en = 1'b0;

      // Reset values
      steps(2);
      chk("rst_req", aref_req, 0);
      chk("rst_end", flag_aref_end, 0);
      chk("rst_cmd", aref_cmd, T_NOP);
      chk("rst_addr", aref_addr, 0);
      chk("rst_ovr", ref_overrun, 0);

      // First refresh with grant tied high
      rst_n = 1'b1;
      flag_init_end = 1'b1;
      aref_en = 1'b1;
      wait_req(1000, n);
      chk("first_req_lat", n, 375);
      chk("req_cmd_nop", aref_cmd, T_NOP);
      wait_cmd(T_PRE, 20, n);
      chk("pre_lat", n, 1);
      chk("pre_addr", aref_addr, T_A10);
      chk("pre_req_low", aref_req, 0);
      wait_cmd(T_REF, 20, n);
      chk("aref_lat", n, 3);
      chk("aref_addr", aref_addr, 0);
      wait_end(20, n);
      chk("end_lat", n, 5);
      step();
      chk("end_pulse_1cyc", flag_aref_end, 0);
      chk("idle_req", aref_req, 0);

      // Period repeat, then grant held off 200 cycles
      aref_en = 1'b0;
      wait_req(1000, n);
      chk("period_req", n, 365);
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         if (aref_req !== 1'b1 || aref_cmd !== T_NOP) bad++;
         step();
      end
      chk("hold_req_nop", bad, 0);
      aref_en = 1'b1;
      wait_cmd(T_PRE, 20, n);
      chk("hold_pre_lat", n, 1);
      wait_cmd(T_REF, 20, n);
      chk("hold_aref_lat", n, 3);
      wait_end(20, n);
      chk("hold_end_lat", n, 5);
      step();
      chk("no_ovr_yet", ref_overrun, 0);

      // Two ticks without grant: one overrun, one sequence
      aref_en = 1'b0;
      wait_req(1000, n);
      chk("ovr_req", n, 165);
      steps(375);
      chk("ovr_flag", ref_overrun, OVR_EXP);
      chk("ovr_req_held", aref_req, 1);
      aref_en = 1'b1;
      wait_cmd(T_PRE, 20, n);
      chk("ovr_pre_lat", n, 1);
      wait_end(20, n);
      chk("ovr_end_lat", n, 8);
      step();
      chk("ovr_no_second", aref_req, 0);
      chk("ovr_sticky", ref_overrun, OVR_EXP);

      // Tick lands in DONE: straight back to REQ
      aref_en = 1'b0;
      wait_req(1000, n);
      chk("bb_req", n, 365);
      steps(365);
      aref_en = 1'b1;
      wait_end(20, n);
      chk("bb_end_lat", n, 9);
      step();
      chk("bb_req_direct", aref_req, 1);
      step();
      chk("bb_pre", aref_cmd, T_PRE);

      // Init drops during WAIT_RFC
      wait_cmd(T_REF, 20, n);
      chk("drop_aref_lat", n, 3);
      step();
      flag_init_end = 1'b0;
      wait_end(20, n);
      chk("drop_end_lat", n, 4);
      step();
      chk("drop_idle_req", aref_req, 0);
      chk("drop_timer", dut.u_timer.count, 0);
      bad = 0;
      for (int i = 0; i < 400; i++) begin
         if (aref_req !== 1'b0) bad++;
         step();
      end
      chk("drop_no_req", bad, 0);

      // Async reset in AREF
      flag_init_end = 1'b1;
      wait_req(1000, n);
      chk("rst_seq_req", n, 375);
      wait_cmd(T_REF, 20, n);
      chk("rst_seq_aref", n, 4);
      rst_n = 1'b0;
      #1;
      chk("arst_cmd", aref_cmd, T_NOP);
      chk("arst_req", aref_req, 0);
      chk("arst_ovr", ref_overrun, 0);
      chk("arst_timer", dut.u_timer.count, 0);
      #1;
      rst_n = 1'b1;
      wait_req(1000, n);
      chk("arst_restart", n, 375);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
